// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor default and receiver FSM state encodings.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 87;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous line that idles high.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit midpoint qualification, LSB-first data, stop-bit framing check.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       input_serial,
  output logic       done,
  output logic [7:0] output_Byte
);

  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

  logic        rx;
  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        done_q, done_d;

  sync2 u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (input_serial),
    .sync_out (rx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx) state_d = START_BIT;
      end
      START_BIT: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rx ? IDLE : DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP_BIT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP_BIT: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          // A low stop bit drops the byte silently; output_Byte keeps the last good frame.
          if (rx) begin
            byte_d  = shift_q;
            done_d  = 1'b1;
            state_d = CLEANUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CLEANUP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
    end
  end

  assign done        = done_q;
  assign output_Byte = byte_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed scoreboard bench for uart_receiver at 87 clocks per bit.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int unsigned CPB     = 87;
  localparam int unsigned LAT_MIN = 2 + (CPB - 1) / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       input_serial;
  logic       done;
  logic [7:0] output_Byte;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_serial (input_serial),
    .done         (done),
    .output_Byte  (output_Byte)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned t0;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  int unsigned cycle = 0;
  logic        done_prev = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected byte and checks value, width and latency.
  always @(negedge clk) begin
    exp_t        e;
    int unsigned lat;
    if (done === 1'b1) begin
      done_count++;
      chk("done_width", {31'd0, done_prev}, 32'd0);
      chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        lat = cycle - e.t0;
        chk("rx_byte", {24'd0, output_Byte}, {24'd0, e.data});
        chk("latency_window", {31'd0, (lat >= LAT_MIN) && (lat < LAT_MIN + CPB)}, 32'd1);
      end
    end
    done_prev = done;
  end

  task automatic idle_bits(input int unsigned n);
    input_serial = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) sb.push_back('{data: b, t0: cycle});
    input_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      input_serial = b[i];
      repeat (CPB) @(negedge clk);
    end
    input_serial = stop;
    repeat (CPB) @(negedge clk);
    input_serial = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    input_serial = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_byte", {24'd0, output_Byte}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_state", {29'd0, dut.state_q}, {29'd0, IDLE});
    chk("rst_sync", {31'd0, dut.u_sync.sync_q}, 32'd1);
    reset = 1'b1;
    idle_bits(1);

    send_frame(8'hA5, 1'b1);
    idle_bits(3);
    chk("a5_done_count", done_count, 1);
    chk("a5_byte", {24'd0, output_Byte}, 32'hA5);
    idle_bits(4);
    chk("a5_hold", {24'd0, output_Byte}, 32'hA5);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle_bits(3);
    chk("b2b_done_count", done_count, 4);
    chk("b2b_sb_empty", sb.size(), 0);

    input_serial = 1'b0;
    repeat (20) @(negedge clk);
    idle_bits(2);
    chk("glitch_done_count", done_count, 4);
    chk("glitch_byte", {24'd0, output_Byte}, 32'h3C);
    chk("glitch_state", {29'd0, dut.state_q}, {29'd0, IDLE});

    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    send_frame(8'h5A, 1'b0);
    idle_bits(3);
    chk("frame_err_done_count", done_count, 5);
    chk("frame_err_byte", {24'd0, output_Byte}, 32'hA5);
    send_frame(8'h81, 1'b1);
    idle_bits(3);
    chk("after_err_done_count", done_count, 6);
    chk("after_err_byte", {24'd0, output_Byte}, 32'h81);

    // 0x77 aborted by reset in the middle of data bit 4.
    input_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      input_serial = 1'(8'h77 >> i);
      repeat (CPB) @(negedge clk);
    end
    input_serial = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_bits(2);
    chk("abort_done_count", done_count, 6);
    chk("abort_byte", {24'd0, output_Byte}, 32'h00);
    send_frame(8'h12, 1'b1);
    idle_bits(3);
    chk("post_rst_done_count", done_count, 7);
    chk("post_rst_byte", {24'd0, output_Byte}, 32'h12);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The parameter CLKS_PER_BIT SHALL default to 87 and set the clock cycles per serial bit (115200 baud at a 10 MHz clk); legal range is 4..65535.
REQ-002 The parameters IDLE, START_BIT, DATA_BITS, STOP_BIT and CLEANUP SHALL default to 0, 1, 2, 3 and 4 respectively and are the state encodings.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single system clock; all logic is rising-edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: synchronous, active-low reset.
REQ-005 Port input_serial SHALL be an input, 1 bit wide: asynchronous UART line, idle high.
REQ-006 Port done SHALL be an output, 1 bit wide: one-cycle pulse when a valid byte is received.
REQ-007 Port output_Byte SHALL be an output, 8 bits wide: the last valid received byte.

Function
REQ-008 input_serial SHALL pass through a 2-flop synchronizer (preset high), and all decisions SHALL use the synchronized bit.
REQ-009 The FSM states SHALL be IDLE, START_BIT, DATA_BITS, STOP_BIT and CLEANUP, with one cycle counter (16 bit) and one bit index (3 bit).
REQ-010 In IDLE, counter and index SHALL be cleared, and a low synchronized bit SHALL move the FSM to START_BIT.
REQ-011 In START_BIT, at counter == (CLKS_PER_BIT-1)/2: if the line is still low, clear the counter and go to DATA_BITS; if high, it is a glitch, return to IDLE with no done.
REQ-012 In DATA_BITS, at counter == CLKS_PER_BIT-1, the line SHALL be sampled into bit[index], LSB first; after index 7 the FSM goes to STOP_BIT, otherwise index increments.
REQ-013 In STOP_BIT, at counter == CLKS_PER_BIT-1: if the line is high, output_Byte SHALL load the shift register, done SHALL be 1 for exactly the next cycle, and the FSM goes to CLEANUP.
REQ-014 A low stop bit SHALL be a framing error: the byte is discarded, output_Byte is unchanged, no done is issued, and the FSM goes to IDLE.
REQ-015 CLEANUP SHALL last one cycle, then go to IDLE; done SHALL be low from then on.
REQ-016 output_Byte SHALL only change on a valid frame and SHALL hold its value indefinitely otherwise.
REQ-017 Back-to-back frames (a start bit immediately after the stop bit) SHALL be received without loss.
REQ-018 Latency SHALL be: done asserts 2 synchronizer cycles + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + a few cycles after the falling start edge, and SHALL always be within one bit time of the stop-bit midpoint.
REQ-019 Line activity during DATA_BITS or STOP_BIT other than at the sample points SHALL be ignored.
REQ-020 Undefined state encodings SHALL recover to IDLE in the next cycle.

Reset
REQ-021 While reset is low at a clk edge, the state SHALL be IDLE, counter/index 0, the shift register 0x00, output_Byte 0x00, done 0, and the synchronizer flops 1.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no done; reception resumes at the next start edge after reset deasserts.

Structure
REQ-023 The state encodings and the default CLKS_PER_BIT SHALL live in a shared package, uart_pkg, also used by the transmitter so the baud rates match.
REQ-024 The design SHALL be a single module; an optional sub-module, sync2 (2-flop synchronizer), is permitted.

Verification (CLKS_PER_BIT=87, clk period 100 ns, bit period 8.7 us)
REQ-025 Reset low for 3 cycles, line high -> output_Byte=0x00, done=0, state IDLE.
REQ-026 Send frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> exactly one done pulse, 1 cycle wide; output_Byte=0xA5 and it holds.
REQ-027 Send 0x00, 0xFF, 0x3C back-to-back with no idle gap -> three done pulses; output_Byte reads 0x00, 0xFF and 0x3C in turn.
REQ-028 Line low pulse of 20 cycles, then high -> return to IDLE, no done, output_Byte unchanged.
REQ-029 Send 0x5A with stop bit low -> no done, output_Byte keeps its previous 0xA5; the next valid frame 0x81 is received correctly.
REQ-030 Assert reset midway through data bit 4 of 0x77, then send 0x12 -> no done for 0x77, done pulse with output_Byte=0x12.
